spi_master_scheduler: RTL and testbench
=======================================

// Module: spi_master_scheduler
//
// PURPOSE
//   Shares one SPI bus between NUM_REQ requesters using round-robin arbitration.
//   Each requester owns one active-low slave-select line. The block runs one
//   8-bit, mode-0, MSB-first full-duplex transfer per grant and returns the
//   received byte. It drives the sck/ss/mosi inputs of the spi_peripheral slaves.
//
// PARAMETERS
//   NUM_REQ  2  number of requesters / slave-select lines (>=1)
//   CLK_DIV  4  clk cycles per sck half-period (>=1)
//
// PORTS
//   clk    in   1          system clock; all state updates on posedge
//   rst    in   1          synchronous, active-high reset
//   req    in   NUM_REQ    transfer request per requester; level, held until done[i]
//   din    in   8*NUM_REQ  tx byte; requester i uses din[8*i+7:8*i]
//   grant  out  NUM_REQ    one-hot; high from acceptance through the done cycle
//   done   out  NUM_REQ    one-cycle pulse to the granted requester; dout valid that cycle
//   dout   out  8          last received byte; held until the next done
//   busy   out  1          high in any state other than IDLE
//   sck    out  1          SPI clock; idles low
//   ss     out  NUM_REQ    active-low selects; at most one low at a time
//   mosi   out  1          serial out, MSB first
//   miso   in   1          serial in
//
// BEHAVIOUR
//   Reset values: grant=0, done=0, dout=0, busy=0, sck=0, ss=all 1, mosi=0,
//     state=IDLE, rr_ptr=0. Reset mid-transfer aborts the transfer with no done.
//   FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE. All outputs registered.
//   IDLE: if any req bit is set in cycle k, grant the first set index at or after
//     rr_ptr, scanning upward and wrapping. Latch din of the winner.
//     From k+1: grant[i]=1, ss[i]=0, mosi=bit7, busy=1.
//   SETUP: CLK_DIV cycles (k+1..k+CLK_DIV) with sck low.
//   SHIFT: 16 half-periods of CLK_DIV cycles each; sck high in the first one.
//     miso is sampled into the rx shift register on the clk edge that ends each
//     high half-period. mosi advances to the next bit on the clk edge that ends
//     each high half-period, except after the 8th bit.
//     sck toggles exactly 16 times. mosi is stable across every sck rise.
//   HOLD: CLK_DIV cycles, sck low, ss still asserted.
//   Completion, cycle k+18*CLK_DIV+1:
//     done[i]=1 and dout=rx byte; ss all 1, grant=0, mosi=0.
//     rr_ptr <= (i+1) mod NUM_REQ.
//   GAP: starts at the done cycle and lasts CLK_DIV cycles with ss all high.
//     IDLE then re-arbitrates.
//   Minimum request-to-request spacing is 19*CLK_DIV+1 cycles.
//   Deasserting req[i] after grant does not abort the transfer; done[i] still fires.
//   req changes during a transfer do not alter the current grant.
//   din changes after the latch cycle are ignored.
//   NUM_REQ=1: rr_ptr stays 0, and back-to-back transfers are spaced by GAP only.
//
// TESTING
//   1. Reset, CLK_DIV=4, req[0]=1, din0=8'hA5, miso looped to mosi
//      -> done[0] at 73 cycles after the req cycle; dout=8'hA5;
//         spi_peripheral slave on ss[0] reports 8'hA5.
//   2. req=2'b11 held, din0=8'h3C, din1=8'hC3
//      -> grants alternate 0,1,0,1; ss[0] and ss[1] are never low together;
//         each slave receives its own byte.
//   3. miso driven from a model returning 8'h96
//      -> dout=8'h96; exactly 16 sck edges and 8 rising edges per transfer;
//         mosi stable at each rise.
//   4. Assert rst at cycle 30 of a transfer
//      -> next cycle: ss=all 1, sck=0, busy=0, no done pulse;
//         a fresh req is granted to index 0.
//   5. Drop req[1] mid-transfer and change din1
//      -> transfer completes with the originally latched byte; done[1] fires once.
//   6. CLK_DIV=1, continuous req[0]
//      -> done every 20 cycles; ss high for >=1 cycle between transfers.

Source files
------------

// File: rtl/spi_master_scheduler.sv
// Round-robin scheduler sharing one mode-0 SPI bus between NUM_REQ requesters.
// Each grant runs one 8-bit MSB-first full-duplex transfer and returns the received byte.
module spi_master_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int CLK_DIV = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [8*NUM_REQ-1:0] din_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic [NUM_REQ-1:0]   done_o,
    output logic [7:0]           dout_o,
    output logic                 busy_o,
    output logic                 sck_o,
    output logic [NUM_REQ-1:0]   ss_o,
    output logic                 mosi_o,
    input  logic                 miso_i,
    output logic [2:0]           state_o
);
    // Handshake: req[i] is a level held by the requester; the block accepts it when
    // idle, asserts grant[i], and closes with a one-cycle done[i] carrying dout.
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d, ss_q, ss_d;
    logic [7:0]         dout_q, dout_d, tx_q, tx_d, rx_q, rx_d;
    logic               busy_q, busy_d, sck_q, sck_d, mosi_q, mosi_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d, idx_q, idx_d, win_idx;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [3:0]         half_q, half_d;
    logic               last_div;

    assign last_div = (div_q == DIV_W'(CLK_DIV - 1));

    // Scan downward so the last hit is the first set index at or after rr_ptr.
    always_comb begin
        win_idx = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (req_i[(int'(rr_ptr_q) + off) % NUM_REQ]) begin
                win_idx = IDX_W'((int'(rr_ptr_q) + off) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = '0;
        ss_d     = ss_q;
        dout_d   = dout_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        busy_d   = busy_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        div_d    = div_q;
        half_d   = half_q;
        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    grant_d = NUM_REQ'(1) << win_idx;
                    ss_d    = ~(NUM_REQ'(1) << win_idx);
                    idx_d   = win_idx;
                    tx_d    = din_i[{win_idx, 3'b000} +: 8];
                    mosi_d  = din_i[{win_idx, 3'b111}];
                    busy_d  = 1'b1;
                    sck_d   = 1'b0;
                    div_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (last_div) begin
                    div_d   = '0;
                    half_d  = '0;
                    sck_d   = 1'b1;
                    state_d = S_SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (last_div) begin
                    div_d = '0;
                    // Even half-periods are sck-high; their closing edge samples and advances.
                    if (!half_q[0]) begin
                        rx_d = {rx_q[6:0], miso_i};
                        if (half_q != 4'd14) begin
                            mosi_d = tx_q[6];
                            tx_d   = {tx_q[6:0], 1'b0};
                        end
                    end
                    if (half_q == 4'd15) begin
                        sck_d   = 1'b0;
                        state_d = S_HOLD;
                    end else begin
                        half_d = half_q + 4'd1;
                        sck_d  = ~sck_q;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (last_div) begin
                    div_d    = '0;
                    done_d   = grant_q;
                    dout_d   = rx_q;
                    ss_d     = '1;
                    grant_d  = '0;
                    mosi_d   = 1'b0;
                    rr_ptr_d = IDX_W'((int'(idx_q) + 1) % NUM_REQ);
                    state_d  = S_GAP;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_GAP: begin
                if (last_div) begin
                    div_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            ss_q     <= '1;
            dout_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            busy_q   <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            div_q    <= '0;
            half_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            ss_q     <= ss_d;
            dout_q   <= dout_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            busy_q   <= busy_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            div_q    <= div_d;
            half_q   <= half_d;
        end
    end

    assign grant_o = grant_q;
    assign done_o  = done_q;
    assign dout_o  = dout_q;
    assign busy_o  = busy_q;
    assign sck_o   = sck_q;
    assign ss_o    = ss_q;
    assign mosi_o  = mosi_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_spi_master_scheduler.sv
// Bench for spi_master_scheduler: a two-requester instance with a behavioural SPI slave,
// plus a single-requester CLK_DIV=1 instance with miso looped back to mosi.
module tb_spi_master_scheduler;
    localparam int D = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req;
    logic [15:0] din;
    logic [1:0]  grant, done, ss;
    logic [7:0]  dout;
    logic        busy, sck, mosi, miso;
    logic [2:0]  state;
    logic        loop_mode;
    logic        slave_miso;

    logic        req1;
    logic [7:0]  din1;
    logic        grant1, done1, ss1, busy1, sck1, mosi1, miso1;
    logic [7:0]  dout1;
    logic [2:0]  state1;

    assign miso  = loop_mode ? mosi : slave_miso;
    assign miso1 = mosi1;

    spi_master_scheduler #(.NUM_REQ(2), .CLK_DIV(D)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .din_i(din), .grant_o(grant),
        .done_o(done), .dout_o(dout), .busy_o(busy), .sck_o(sck), .ss_o(ss),
        .mosi_o(mosi), .miso_i(miso), .state_o(state)
    );

    spi_master_scheduler #(.NUM_REQ(1), .CLK_DIV(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .din_i(din1), .grant_o(grant1),
        .done_o(done1), .dout_o(dout1), .busy_o(busy1), .sck_o(sck1), .ss_o(ss1),
        .mosi_o(mosi1), .miso_i(miso1), .state_o(state1)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural SPI slave (mode 0) ----------------
    logic [7:0] slv_tx[2];
    logic [7:0] slv_got[2];
    int         slv_edges[2], slv_rises[2], slv_unstable[2];
    int         overlap_cnt = 0;
    logic       prev_sck = 1'b0, prev_mosi = 1'b0;
    logic [1:0] prev_ss = 2'b11;
    logic [7:0] sh_tx = '0, sh_rx = '0;
    int         e_cnt = 0, r_cnt = 0, u_cnt = 0;

    initial begin
        slave_miso = 1'b0;
        for (int j = 0; j < 2; j++) begin
            slv_tx[j] = '0; slv_got[j] = '0;
            slv_edges[j] = 0; slv_rises[j] = 0; slv_unstable[j] = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (ss === 2'b00) overlap_cnt++;
        for (int j = 0; j < 2; j++) begin
            if (prev_ss[j] === 1'b1 && ss[j] === 1'b0) begin
                sh_tx = slv_tx[j];
                slave_miso = sh_tx[7];
                sh_rx = '0; e_cnt = 0; r_cnt = 0; u_cnt = 0;
            end
        end
        if (ss !== 2'b11 && sck !== prev_sck) begin
            e_cnt++;
            if (sck === 1'b1) begin
                r_cnt++;
                sh_rx = {sh_rx[6:0], mosi};
                if (mosi !== prev_mosi) u_cnt++;
            end else begin
                sh_tx = {sh_tx[6:0], 1'b0};
                slave_miso = sh_tx[7];
            end
        end
        for (int j = 0; j < 2; j++) begin
            if (prev_ss[j] === 1'b0 && ss[j] === 1'b1) begin
                slv_got[j] = sh_rx; slv_edges[j] = e_cnt;
                slv_rises[j] = r_cnt; slv_unstable[j] = u_cnt;
            end
        end
        prev_ss = ss; prev_sck = sck; prev_mosi = mosi;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1; req = '0; req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat, output logic [1:0] dv,
                             output logic [1:0] gv, output logic [7:0] dval);
        lat = -1; dv = '0; gv = '0; dval = '0;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk); #1;
            if (gv == 2'b00 && grant != 2'b00) gv = grant;
            if (done != 2'b00) begin
                lat = n; dv = done; dval = dout;
                break;
            end
        end
    endtask

    task automatic wait_done1(input int budget, output int lat, output logic [7:0] dval,
                              output logic ssv);
        lat = -1; dval = '0; ssv = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk); #1;
            if (done1 === 1'b1) begin
                lat = n; dval = dout1; ssv = ss1;
                break;
            end
        end
    endtask

    // One complete transfer from idle; expected values come from the caller.
    task automatic run_xfer(input string tag, input logic [1:0] r, input logic [7:0] d0,
                            input logic [7:0] d1, input logic [7:0] s0, input logic [7:0] s1,
                            input logic lp, input logic [1:0] exp_done, input logic [7:0] exp_got);
        int lat; logic [1:0] dv, gv; logic [7:0] dval; int w;
        loop_mode = lp; slv_tx[0] = s0; slv_tx[1] = s1;
        din = {d1, d0}; req = r;
        exp_q.push_back(lp ? exp_got : (exp_done[1] ? s1 : s0));
        wait_done(200, lat, dv, gv, dval);
        req = '0;
        check({tag, " latency"}, lat, 32'(18 * D + 1));
        check({tag, " done"}, dv, exp_done);
        check({tag, " grant"}, gv, exp_done);
        check({tag, " dout"}, dval, exp_q.pop_front());
        repeat (D + 2) @(posedge clk);
        #1;
        w = exp_done[1] ? 1 : 0;
        check({tag, " busy idle"}, busy, 1'b0);
        check({tag, " slave rx"}, slv_got[w], exp_got);
        check({tag, " sck edges"}, slv_edges[w], 16);
        check({tag, " sck rises"}, slv_rises[w], 8);
        check({tag, " mosi stable"}, slv_unstable[w], 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] req;
        logic [7:0] d0, d1, s0, s1;
        logic       lp;
        logic [1:0] exp_done;
        logic [7:0] exp_got;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int lat; logic [1:0] dv, gv; logic [7:0] dval; logic ssv;
        int rr_m; logic [1:0] r; logic [7:0] d[2], s[2]; int w; int extra;

        // round-robin history from reset: rr 0 ->1 ->0 ->1 ->1 ->0 ->0
        tbl[0] = '{2'b01, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b1, 2'b01, 8'hA5};
        tbl[1] = '{2'b11, 8'h3C, 8'hC3, 8'h00, 8'h96, 1'b0, 2'b10, 8'hC3};
        tbl[2] = '{2'b11, 8'h3C, 8'hC3, 8'h69, 8'h00, 1'b0, 2'b01, 8'h3C};
        tbl[3] = '{2'b01, 8'h5A, 8'h00, 8'h0F, 8'h00, 1'b0, 2'b01, 8'h5A};
        tbl[4] = '{2'b10, 8'h00, 8'h81, 8'h00, 8'h96, 1'b0, 2'b10, 8'h81};
        tbl[5] = '{2'b10, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 2'b10, 8'hFF};

        loop_mode = 1'b0; din = '0; din1 = '0;
        do_reset();

        check("rst grant", grant, 2'b00);
        check("rst done", done, 2'b00);
        check("rst dout", dout, 8'h00);
        check("rst busy", busy, 1'b0);
        check("rst sck", sck, 1'b0);
        check("rst ss", ss, 2'b11);
        check("rst mosi", mosi, 1'b0);
        check("rst state", state, 3'd0);
        check("rst ss1", ss1, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run_xfer($sformatf("vec%0d", i), tbl[i].req, tbl[i].d0, tbl[i].d1,
                     tbl[i].s0, tbl[i].s1, tbl[i].lp, tbl[i].exp_done, tbl[i].exp_got);
        end

        // randomized transfers against a transaction-level round-robin model
        rr_m = 0;
        for (int i = 0; i < 16; i++) begin
            r = 2'($urandom_range(1, 3));
            for (int j = 0; j < 2; j++) begin
                d[j] = 8'($urandom); s[j] = 8'($urandom);
            end
            w = r[rr_m] ? rr_m : 1 - rr_m;
            run_xfer($sformatf("rnd%0d", i), r, d[0], d[1], s[0], s[1], 1'b0,
                     (w == 1) ? 2'b10 : 2'b01, d[w]);
            rr_m = (w + 1) % 2;
        end

        // held req=11 alternates grants; selects never overlap
        do_reset();
        loop_mode = 1'b0; din = {8'hC3, 8'h3C};
        slv_tx[0] = 8'h11; slv_tx[1] = 8'h22;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_done(200, lat, dv, gv, dval);
            if (i == 3) req = '0;
            check($sformatf("alt%0d latency", i), lat, (i == 0) ? 32'(18 * D + 1) : 32'(19 * D + 1));
            check($sformatf("alt%0d done", i), dv, (i % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("alt%0d dout", i), dval, (i % 2 == 0) ? 8'h11 : 8'h22);
        end
        repeat (D + 2) @(posedge clk);
        #1;
        check("alt slave0 rx", slv_got[0], 8'h3C);
        check("alt slave1 rx", slv_got[1], 8'hC3);

        // reset mid-transfer clears rr_ptr and aborts without done
        do_reset();
        run_xfer("pre_abort", 2'b01, 8'h77, 8'h00, 8'h00, 8'h00, 1'b1, 2'b01, 8'h77);
        din = {8'hE7, 8'h18}; req = 2'b10;
        repeat (30) @(posedge clk);
        #1 rst = 1'b1; req = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort ss", ss, 2'b11);
        check("abort sck", sck, 1'b0);
        check("abort busy", busy, 1'b0);
        check("abort grant", grant, 2'b00);
        check("abort done", done, 2'b00);
        extra = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (done != 2'b00) extra++;
        end
        check("abort no done", extra, 0);
        run_xfer("post_abort", 2'b11, 8'h18, 8'hE7, 8'h42, 8'h24, 1'b0, 2'b01, 8'h18);

        // drop req[1] and change din1 mid-transfer
        loop_mode = 1'b0; slv_tx[1] = 8'hB4;
        din = {8'h5A, 8'h00}; req = 2'b10;
        repeat (20) @(posedge clk);
        #1 req = '0; din = {8'hA5, 8'h00};
        wait_done(200, lat, dv, gv, dval);
        check("drop latency", lat, 32'(18 * D + 1 - 20));
        check("drop done", dv, 2'b10);
        check("drop dout", dval, 8'hB4);
        extra = 0;
        for (int n = 0; n < 150; n++) begin
            @(posedge clk); #1;
            if (done != 2'b00) extra++;
        end
        check("drop single done", extra, 0);
        check("drop slave rx", slv_got[1], 8'h5A);

        // CLK_DIV=1, single requester, continuous request
        din1 = 8'h5C; req1 = 1'b1;
        wait_done1(100, lat, dval, ssv);
        check("d1 first latency", lat, 19);
        check("d1 first dout", dval, 8'h5C);
        for (int i = 0; i < 5; i++) begin
            din1 = 8'($urandom);
            exp_q.push_back(din1);
            check($sformatf("d1 ss gap%0d a", i), ssv, 1'b1);
            @(posedge clk); #1;
            check($sformatf("d1 ss gap%0d b", i), ss1, 1'b1);
            wait_done1(100, lat, dval, ssv);
            check($sformatf("d1 period%0d", i), lat + 1, 20);
            check($sformatf("d1 dout%0d", i), dval, exp_q.pop_front());
        end
        req1 = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        check("ss overlap", overlap_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
